// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-outstanding arbiter of fetch and MEM-stage requests onto one bus master port
// Optional macro ARB_STARVE_GUARD_EN: lets a waiting fetch win after STARVE_LIMIT back-to-back data grants.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic                inst_gnt_o,
  output logic                inst_rvalid_o,
  output logic [DATA_W-1:0]   inst_rdata_o,
  input  logic                flush_i,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_sel_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                busy_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ_I,
    REQ_D,
    WAIT_I,
    WAIT_D
  } state_t;

  state_t            state_q, state_d;
  logic              drop_q, drop_d;
  logic              bus_we_q, bus_we_d;
  logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              inst_rvalid_q, inst_rvalid_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic              data_rvalid_q, data_rvalid_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_gnt, data_gnt;
  logic              starve_hit;
  logic              inst_wins;

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_q, starve_d;

  assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));

  // Count data grants taken over a waiting fetch; saturate rather than wrap.
  always_comb begin
    starve_d = starve_q;
    if (inst_gnt) begin
      starve_d = '0;
    end else if (data_gnt) begin
      if (!inst_req_i) begin
        starve_d = '0;
      end else if (!starve_hit) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Fetch overrides data priority only when the guard has tripped.
  assign inst_wins = starve_hit && inst_req_i && !flush_i;

  // Next-state, grant and capture logic; captured bus fields hold outside IDLE.
  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    inst_gnt      = 1'b0;
    data_gnt      = 1'b0;
    bus_we_d      = bus_we_q;
    bus_sel_d     = bus_sel_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    inst_rvalid_d = 1'b0;
    inst_rdata_d  = inst_rdata_q;
    data_rvalid_d = 1'b0;
    data_rdata_d  = data_rdata_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        // No grant while reset is held, so nothing is captured and all outputs stay low.
        if (!rst) begin
          if (data_req_i && !inst_wins) begin
            data_gnt    = 1'b1;
            bus_we_d    = data_we_i;
            bus_sel_d   = data_sel_i;
            bus_addr_d  = data_addr_i;
            bus_wdata_d = data_wdata_i;
            state_d     = REQ_D;
          end else if (inst_req_i && !flush_i) begin
            inst_gnt   = 1'b1;
            bus_we_d   = 1'b0;
            bus_sel_d  = '1;
            bus_addr_d = inst_addr_i;
            state_d    = REQ_I;
          end
        end
      end
      REQ_I: begin
        if (flush_i)   drop_d  = 1'b1;
        if (bus_gnt_i) state_d = WAIT_I;
      end
      REQ_D: begin
        if (bus_gnt_i) state_d = WAIT_D;
      end
      WAIT_I: begin
        if (bus_rvalid_i) begin
          // A flushed fetch still drains the bus but its data never reaches IF.
          if (!(drop_q || flush_i)) begin
            inst_rvalid_d = 1'b1;
            inst_rdata_d  = bus_rdata_i;
          end
          drop_d  = 1'b0;
          state_d = IDLE;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      WAIT_D: begin
        if (bus_rvalid_i) begin
          data_rvalid_d = 1'b1;
          data_rdata_d  = bus_rdata_i;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured bus fields and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      drop_q        <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_sel_q     <= '0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      inst_rvalid_q <= 1'b0;
      inst_rdata_q  <= '0;
      data_rvalid_q <= 1'b0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      bus_we_q      <= bus_we_d;
      bus_sel_q     <= bus_sel_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      inst_rvalid_q <= inst_rvalid_d;
      inst_rdata_q  <= inst_rdata_d;
      data_rvalid_q <= data_rvalid_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign inst_gnt_o    = inst_gnt;
  assign data_gnt_o    = data_gnt;
  assign inst_rvalid_o = inst_rvalid_q;
  assign inst_rdata_o  = inst_rdata_q;
  assign data_rvalid_o = data_rvalid_q;
  assign data_rdata_o  = data_rdata_q;
  assign bus_req_o     = (state_q == REQ_I) || (state_q == REQ_D);
  assign bus_we_o      = bus_we_q;
  assign bus_sel_o     = bus_sel_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed vector bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_i, flush_i, data_req_i, data_we_i;
  logic [31:0] inst_addr_i, data_addr_i, data_wdata_i, bus_rdata_i;
  logic [3:0]  data_sel_i;
  logic        bus_gnt_i, bus_rvalid_i;
  logic        inst_gnt_o, inst_rvalid_o, data_gnt_o, data_rvalid_o;
  logic [31:0] inst_rdata_o, data_rdata_o, bus_addr_o, bus_wdata_o;
  logic        bus_req_o, bus_we_o, busy_o;
  logic [3:0]  bus_sel_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
    .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o), .flush_i(flush_i),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .busy_o(busy_o)
  );

  typedef logic [138:0] obus_t;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        flush;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dsel;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic        bgnt;
    logic        brv;
    logic [31:0] brd;
    obus_t       exp;
  } vec_t;

  vec_t vecs[$];
  obus_t act;

  assign act = {inst_gnt_o, inst_rvalid_o, inst_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o,
                bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, busy_o};

  function automatic obus_t o(input logic ig, input logic irv, input logic [31:0] ird,
                              input logic dg, input logic drv, input logic [31:0] drd,
                              input logic breq, input logic bwe, input logic [3:0] bsel,
                              input logic [31:0] baddr, input logic [31:0] bwd, input logic busy);
    return {ig, irv, ird, dg, drv, drd, breq, bwe, bsel, baddr, bwd, busy};
  endfunction

  function automatic vec_t mk(input logic ireq, input logic [31:0] iaddr, input logic flush,
                              input logic dreq, input logic dwe, input logic [3:0] dsel,
                              input logic [31:0] daddr, input logic [31:0] dwd,
                              input logic bgnt, input logic brv, input logic [31:0] brd,
                              input obus_t exp);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.flush = flush; v.dreq = dreq; v.dwe = dwe;
    v.dsel = dsel; v.daddr = daddr; v.dwd = dwd; v.bgnt = bgnt; v.brv = brv;
    v.brd = brd; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input obus_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (ig irv ird dg drv drd breq bwe sel addr wdata busy)",
               name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_req_i = 0; inst_addr_i = 0; flush_i = 0; data_req_i = 0; data_we_i = 0;
    data_sel_i = 0; data_addr_i = 0; data_wdata_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0;
    bus_rdata_i = 0;
  endtask

  initial begin
    int    got;
    string order;
    string want;

    rst = 1'b1;
    idle_inputs();
    inst_req_i = 1; data_req_i = 1; data_sel_i = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", '0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;

    // single fetch
    vecs.push_back(mk(1, 32'h1C000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h1C000000, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h1C000000, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 32'h1C000000, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h02800C0C, o(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 32'h1C000000, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 1, 32'h02800C0C, 0, 0, 0, 0, 0, 4'hF, 32'h1C000000, 0, 0)));
    // collision: data first, fetch granted on the data rvalid cycle
    vecs.push_back(mk(1, 32'h1C000004, 0, 1, 0, 4'hF, 32'h1000, 0, 0, 0, 0, o(0, 0, 32'h02800C0C, 1, 0, 0, 0, 0, 4'hF, 32'h1C000000, 0, 0)));
    vecs.push_back(mk(1, 32'h1C000004, 0, 0, 0, 0, 0, 0, 1, 0, 0, o(0, 0, 32'h02800C0C, 0, 0, 0, 1, 0, 4'hF, 32'h1000, 0, 1)));
    vecs.push_back(mk(1, 32'h1C000004, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11223344, o(0, 0, 32'h02800C0C, 0, 0, 0, 0, 0, 4'hF, 32'h1000, 0, 1)));
    vecs.push_back(mk(1, 32'h1C000004, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(1, 0, 32'h02800C0C, 0, 1, 32'h11223344, 0, 0, 4'hF, 32'h1000, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, o(0, 0, 32'h02800C0C, 0, 0, 32'h11223344, 1, 0, 4'hF, 32'h1C000004, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000AAAA, o(0, 0, 32'h02800C0C, 0, 0, 32'h11223344, 0, 0, 4'hF, 32'h1C000004, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 1, 32'h0000AAAA, 0, 0, 32'h11223344, 0, 0, 4'hF, 32'h1C000004, 0, 0)));
    // store with a bus wait state before the grant
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'b0100, 32'h2000, 32'h00AB0000, 0, 0, 0, o(0, 0, 32'h0000AAAA, 1, 0, 32'h11223344, 0, 0, 4'hF, 32'h1C000004, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 32'h0000AAAA, 0, 0, 32'h11223344, 1, 1, 4'b0100, 32'h2000, 32'h00AB0000, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, o(0, 0, 32'h0000AAAA, 0, 0, 32'h11223344, 1, 1, 4'b0100, 32'h2000, 32'h00AB0000, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 32'h0000AAAA, 0, 0, 32'h11223344, 0, 1, 4'b0100, 32'h2000, 32'h00AB0000, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, o(0, 0, 32'h0000AAAA, 0, 0, 32'h11223344, 0, 1, 4'b0100, 32'h2000, 32'h00AB0000, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 32'h0000AAAA, 0, 1, 32'hDEADBEEF, 0, 1, 4'b0100, 32'h2000, 32'h00AB0000, 0)));
    // fetch flushed while waiting for the response
    vecs.push_back(mk(1, 32'h1C000008, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(1, 0, 32'h0000AAAA, 0, 0, 32'hDEADBEEF, 0, 1, 4'b0100, 32'h2000, 32'h00AB0000, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, o(0, 0, 32'h0000AAAA, 0, 0, 32'hDEADBEEF, 1, 0, 4'hF, 32'h1C000008, 32'h00AB0000, 1)));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 32'h0000AAAA, 0, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h1C000008, 32'h00AB0000, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55555555, o(0, 0, 32'h0000AAAA, 0, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h1C000008, 32'h00AB0000, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 32'h0000AAAA, 0, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h1C000008, 32'h00AB0000, 0)));
    // flush in IDLE blocks the fetch grant; data request waits behind a busy fetch
    vecs.push_back(mk(1, 32'h1C00000C, 1, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 32'h0000AAAA, 0, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h1C000008, 32'h00AB0000, 0)));
    vecs.push_back(mk(1, 32'h1C00000C, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(1, 0, 32'h0000AAAA, 0, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h1C000008, 32'h00AB0000, 0)));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'hF, 32'h3000, 0, 1, 0, 0, o(0, 0, 32'h0000AAAA, 0, 0, 32'hDEADBEEF, 1, 0, 4'hF, 32'h1C00000C, 32'h00AB0000, 1)));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'hF, 32'h3000, 0, 0, 1, 32'h12345678, o(0, 0, 32'h0000AAAA, 0, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h1C00000C, 32'h00AB0000, 1)));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'hF, 32'h3000, 0, 0, 0, 0, o(0, 1, 32'h12345678, 1, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h1C00000C, 32'h00AB0000, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, o(0, 0, 32'h12345678, 0, 0, 32'hDEADBEEF, 1, 0, 4'hF, 32'h3000, 0, 1)));
    // flush during a data wait has no effect
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, o(0, 0, 32'h12345678, 0, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h3000, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 32'h12345678, 0, 1, 32'hCAFEF00D, 0, 0, 4'hF, 32'h3000, 0, 0)));
    // stray response in IDLE is ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, o(0, 0, 32'h12345678, 0, 0, 32'hCAFEF00D, 0, 0, 4'hF, 32'h3000, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 32'h12345678, 0, 0, 32'hCAFEF00D, 0, 0, 4'hF, 32'h3000, 0, 0)));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      inst_req_i = vecs[i].ireq; inst_addr_i = vecs[i].iaddr; flush_i = vecs[i].flush;
      data_req_i = vecs[i].dreq; data_we_i = vecs[i].dwe; data_sel_i = vecs[i].dsel;
      data_addr_i = vecs[i].daddr; data_wdata_i = vecs[i].dwd; bus_gnt_i = vecs[i].bgnt;
      bus_rvalid_i = vecs[i].brv; bus_rdata_i = vecs[i].brd;
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // reset in WAIT_D, then a stray response
    @(posedge clk); #1;
    idle_inputs();
    data_req_i = 1; data_sel_i = 4'hF; data_addr_i = 32'h4000;
    @(negedge clk);
    check("rst_seq_gnt", o(0, 0, 32'h12345678, 1, 0, 32'hCAFEF00D, 0, 0, 4'hF, 32'h3000, 0, 0));
    @(posedge clk); #1;
    idle_inputs();
    bus_gnt_i = 1;
    @(negedge clk);
    check("rst_seq_req", o(0, 0, 32'h12345678, 0, 0, 32'hCAFEF00D, 1, 0, 4'hF, 32'h4000, 0, 1));
    @(posedge clk); #1;
    bus_gnt_i = 0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_seq_wait", o(0, 0, 32'h12345678, 0, 0, 32'hCAFEF00D, 0, 0, 4'hF, 32'h4000, 0, 1));
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rvalid_i = 1; bus_rdata_i = 32'h77777777;
    @(negedge clk);
    check("rst_stray", '0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rst_after", '0);

    // both requesters held high; bus always accepts and answers immediately
    @(posedge clk); #1;
    inst_req_i = 1; inst_addr_i = 32'h1C000100;
    data_req_i = 1; data_sel_i = 4'hF; data_addr_i = 32'h5000;
    bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'h0BADF00D;
`ifdef ARB_STARVE_GUARD_EN
    want = "DDIDDI";
`else
    want = "DDDDDD";
`endif
    order = "";
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
      @(negedge clk);
      if (inst_gnt_o && data_gnt_o) begin
        total++; bad++;
        $display("FAIL starve_double_gnt: both grants high at cycle %0d", cyc);
      end
      if (data_gnt_o) begin order = {order, "D"}; got++; end
      else if (inst_gnt_o) begin order = {order, "I"}; got++; end
      @(posedge clk); #1;
    end
    total++;
    if (got < 6) begin
      bad++;
      $display("FAIL starve_timeout: saw %0d grants (%s), need 6", got, order);
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (k >= got || order[k] != want[k]) begin
        bad++;
        $display("FAIL starve_order%0d: got %s want %s", k, order, want);
      end
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory-bus master port between the instruction-fetch requester and the MEM-stage data requester (loads, stores, LL/SC).
- Allows one outstanding transaction. Data requests have priority. Each grant, bus handshake and response is sequenced by a small FSM.
- Sits between the IF/MEM stages and the AXI bridge. busy_o feeds the pipeline ctrl stall logic.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Byte-select width is DATA_W/8.
- STARVE_LIMIT, 8, consecutive data grants allowed while inst_req_i is waiting (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- inst_req_i  in  1  fetch request; held until inst_gnt_o.
- inst_addr_i  in  ADDR_W  fetch address.
- inst_gnt_o  out  1  one-cycle pulse: fetch request captured.
- inst_rvalid_o  out  1  one-cycle pulse: fetch data valid.
- inst_rdata_o  out  DATA_W  fetch data.
- flush_i  in  1  pipeline flush; discards any fetch in flight.
- data_req_i  in  1  MEM-stage request; held until data_gnt_o.
- data_we_i  in  1  1 = store.
- data_sel_i  in  DATA_W/8  byte enables.
- data_addr_i  in  ADDR_W  data address.
- data_wdata_i  in  DATA_W  store data.
- data_gnt_o  out  1  one-cycle pulse: data request captured.
- data_rvalid_o  out  1  one-cycle pulse: load data valid or store completed.
- data_rdata_o  out  DATA_W  load data.
- bus_req_o  out  1  request to bus, held until bus_gnt_i.
- bus_we_o  out  1  write enable to bus.
- bus_sel_o  out  DATA_W/8  byte enables to bus.
- bus_addr_o  out  ADDR_W  address to bus.
- bus_wdata_o  out  DATA_W  write data to bus.
- bus_gnt_i  in  1  bus accepted the request.
- bus_rvalid_i  in  1  bus response (read data or write ack).
- bus_rdata_i  in  DATA_W  bus read data.
- busy_o  out  1  FSM not IDLE.

Behaviour:
- FSM states: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D.
- IDLE:
  - data_req_i=1 → data_gnt_o=1 (combinational), capture we/sel/addr/wdata, go to REQ_D.
  - else inst_req_i=1 and flush_i=0 → inst_gnt_o=1, capture addr, we=0, sel=all ones, go to REQ_I.
  - inst_req_i=1 with flush_i=1 → not granted this cycle.
- REQ_x: bus_req_o=1, bus_* driven from captured registers.
  - bus_gnt_i=1 → WAIT_x next cycle.
  - bus_req_o rises the cycle after the gnt pulse. Captured fields never change while in REQ_x/WAIT_x.
- WAIT_x: bus_req_o=0.
  - bus_rvalid_i=1 → register bus_rdata_i into x_rdata_o, pulse x_rvalid_o the next cycle, return to IDLE.
  - A new grant may issue in the same cycle x_rvalid_o pulses.
- bus_rvalid_i outside WAIT_x is ignored. This covers stray responses after reset.
- Stores also wait for bus_rvalid_i (write ack). data_rdata_o is don't-care for stores but is still loaded with bus_rdata_i.
- Flush:
  - flush_i in REQ_I or WAIT_I sets drop flag. The bus request is not retracted and the transaction completes.
  - The matching inst_rvalid_o is suppressed. Drop flag clears on return to IDLE.
  - flush_i does not affect data transactions.
- x_rdata_o holds its last value between pulses.
- Reset: state=IDLE, drop=0, starve counter=0. All outputs 0, including rdata and the bus_* registers. Reset mid-transaction abandons it with no rvalid pulse.
- Arithmetic: the starve counter saturates at STARVE_LIMIT and never wraps.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - Counter increments on each data grant taken while inst_req_i=1.
  - Counter clears on any inst grant, or when a data grant is taken with inst_req_i=0.
  - When the counter equals STARVE_LIMIT and both requests are pending in IDLE (flush_i=0), inst wins.
- Undefined: strict data priority, no counter logic.

Test Plan:
- Single fetch: inst_req_i=1 addr 0x1C000000 → inst_gnt_o pulse at cycle 0, bus_req_o=1 from cycle 1. bus_gnt_i at cycle 2, bus_rvalid_i with rdata 0x02800C0C at cycle 4 → inst_rvalid_o=1 with 0x02800C0C at cycle 5, busy_o=0 at cycle 5.
- Collision: inst_req_i and data_req_i both high in IDLE → data granted first. After its rvalid, inst granted in the same cycle data_rvalid_o pulses.
- Store: data_we_i=1, sel 4'b0100, wdata 0x00AB0000 → bus_we_o=1, bus_sel_o=4'b0100, bus_wdata_o=0x00AB0000. data_rvalid_o pulses one cycle after the write ack.
- Flush: flush_i asserted in WAIT_I → bus response consumed, inst_rvalid_o stays 0, FSM back in IDLE.
- Reset: rst in WAIT_D, then stray bus_rvalid_i next cycle → no rvalid pulse, all outputs 0, state IDLE.
- With ARB_STARVE_GUARD_EN, STARVE_LIMIT=2: data_req_i and inst_req_i held high → order D, D, I, D, D, I. Without the macro → only D grants.
